// File: rtl/obi_mem_tester.sv
// obi_mem_tester: single-outstanding memory-port initiator.
// It writes pattern(a) to words 0..NumWords-1, reads them back and counts
// every word that does not match. Grant and response latency may be random.
// If a response takes too long after its grant, the run is aborted.
module obi_mem_tester #(
  parameter int unsigned AddrWidth     = 10,
  parameter int unsigned NumWords      = 1024,
  parameter logic [31:0] Seed          = 32'hA5C3_0F1E,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [31:0]          wdata_o,
  output logic [3:0]           be_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [31:0]          rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [15:0]          err_count_o,
  output logic [AddrWidth-1:0] first_err_addr_o
);

  localparam int unsigned           TimerWidth = $clog2(TimeoutCycles + 1);
  localparam logic [AddrWidth-1:0]  LastAddr   = AddrWidth'(NumWords - 1);
  localparam logic [TimerWidth-1:0] TimerLast  = TimerWidth'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_e;

  // The data expected at word address a: Seed ^ (a * 0x0001_0001).
  function automatic logic [31:0] pattern(input logic [AddrWidth-1:0] a);
    logic [31:0] ext;
    ext = 32'(a);
    return Seed ^ (ext * 32'h0001_0001);
  endfunction

  state_e                r_state;
  logic [AddrWidth-1:0]  r_addr;        // word currently being processed
  logic [TimerWidth-1:0] r_timer;       // wait cycles since the last grant
  logic                  r_req;
  logic                  r_we;
  logic [AddrWidth-1:0]  r_addr_o;      // zero whenever no request is active
  logic [31:0]           r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_timeout;
  logic [15:0]           r_err_count;
  logic [AddrWidth-1:0]  r_first_err;

  logic                  w_issue_we;
  logic [AddrWidth-1:0]  w_issue_addr;
  logic [31:0]           w_issue_wdata;
  logic [AddrWidth-1:0]  w_next_addr;
  logic                  w_rd_mismatch;
  logic                  w_err_sat;

  assign w_next_addr   = r_addr + 1'b1;
  assign w_rd_mismatch = (rdata_i != pattern(r_addr));
  assign w_err_sat     = &r_err_count;
  assign w_issue_wdata = w_issue_we ? pattern(w_issue_addr) : 32'h0;

  // Select the next request to issue once the current word completes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_issue_we   = 1'b1;
    w_issue_addr = '0;
    case (r_state)
      S_WR_WAIT: begin
        if (r_addr == LastAddr) begin
          w_issue_we = 1'b0;
        end else begin
          w_issue_addr = w_next_addr;
        end
      end
      S_RD_WAIT: begin
        w_issue_we   = 1'b0;
        w_issue_addr = w_next_addr;
      end
      default: ;
    endcase
  end

  // Control FSM with registered bus and status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: reset is asynchronous, so a reset in the middle of a run drops
    // req_o at once instead of waiting for the next clock edge.
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_timer     <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr_o    <= '0;
      r_wdata     <= 32'h0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_count <= 16'h0;
      r_first_err <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every branch below reads the
      // values the registers held before this clock edge.
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_err_count <= 16'h0;
            r_first_err <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b1;
            r_addr      <= w_issue_addr;
            r_req       <= 1'b1;
            r_we        <= w_issue_we;
            r_addr_o    <= w_issue_addr;
            r_wdata     <= w_issue_wdata;
            r_state     <= S_WR_REQ;
          end
        end

        S_WR_REQ, S_RD_REQ: begin
          // The request outputs stay unchanged until the responder grants it.
          if (gnt_i) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr_o <= '0;
            r_wdata  <= 32'h0;
            r_timer  <= '0;
            r_state  <= (r_state == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
          end
        end

        S_WR_WAIT, S_RD_WAIT: begin
          if (rvalid_i) begin
            if (r_state == S_RD_WAIT && w_rd_mismatch) begin
              if (!w_err_sat) begin
                r_err_count <= r_err_count + 16'd1;
              end
              if (r_err_count == 16'h0) begin
                r_first_err <= r_addr;
              end
            end
            if (r_state == S_RD_WAIT && r_addr == LastAddr) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_addr   <= w_issue_addr;
              r_req    <= 1'b1;
              r_we     <= w_issue_we;
              r_addr_o <= w_issue_addr;
              r_wdata  <= w_issue_wdata;
              r_state  <= w_issue_we ? S_WR_REQ : S_RD_REQ;
            end
          end else if (r_timer == TimerLast) begin
            // The responder has had TimeoutCycles wait cycles. Abort the run
            // and keep the mismatch count gathered so far.
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_o            = r_req;
  assign we_o             = r_we;
  assign addr_o           = r_addr_o;
  assign wdata_o          = r_wdata;
  assign be_o             = 4'hF;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign timeout_o        = r_timeout;
  assign err_count_o      = r_err_count;
  assign first_err_addr_o = r_first_err;

endmodule

// File: tb/tb_obi_mem_tester.sv
// Directed bench for obi_mem_tester with NumWords=4. The bench contains a
// configurable memory responder. The responder can grant at random, add a
// fixed or random response delay, corrupt read data, or drop one response.
module tb_obi_mem_tester;

  localparam int AW = 4;

  logic          clk_i;
  logic          rst_ni;
  logic          start_i;
  logic          req_o;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic [3:0]    be_o;
  logic          gnt_i;
  logic          rvalid_i;
  logic [31:0]   rdata_i;
  logic          busy_o;
  logic          done_o;
  logic          timeout_o;
  logic [15:0]   err_count_o;
  logic [AW-1:0] first_err_addr_o;

  obi_mem_tester #(
    .AddrWidth(AW), .NumWords(4), .Seed(32'hA5C3_0F1E), .TimeoutCycles(64)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Count of rising edges so far. It is used to measure latencies.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Responder configuration and state.
  bit          rand_gnt, rand_dly, drop_wr1;
  int          fixed_dly;
  logic [31:0] mem [16];
  logic [31:0] corrupt [16];
  bit          pending, stuck, pend_we, rd_granted, prev_stall;
  int          cnt, n_gnt, outst_err, stab_err, stuck_cyc;
  logic [AW-1:0] pend_addr, prev_addr;
  logic        prev_we;
  logic [31:0] prev_wdata;

  // Responder. It runs on the falling edge, so the DUT samples its gnt_i,
  // rvalid_i and rdata_i at the next rising edge. Here fixed_dly is the
  // distance in cycles from the grant cycle to the rvalid cycle.
  always @(negedge clk_i) begin
    rvalid_i = 1'b0;
    if (pending && !stuck) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        rvalid_i = 1'b1;
        rdata_i  = pend_we ? 32'h0 : (mem[pend_addr] ^ corrupt[pend_addr]);
        pending  = 1'b0;
      end
    end
    gnt_i = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (!rst_ni) prev_stall = 1'b0;
    if (prev_stall && (req_o !== 1'b1 || we_o !== prev_we || addr_o !== prev_addr ||
                       wdata_o !== prev_wdata))
      stab_err++;
    if (req_o === 1'b1) begin
      if (pending || rvalid_i) outst_err++;
      if (gnt_i) begin
        n_gnt++;
        pending   = 1'b1;
        pend_we   = we_o;
        pend_addr = addr_o;
        stuck     = drop_wr1 && we_o && (addr_o == 1);
        cnt       = rand_dly ? int'($urandom_range(1, 32)) : fixed_dly;
        if (stuck) stuck_cyc = cyc + 1;
        if (we_o) mem[addr_o] = wdata_o;
        else      rd_granted = 1'b1;
      end
    end
    prev_stall = (req_o === 1'b1) && !gnt_i;
    prev_we    = we_o;
    prev_addr  = addr_o;
    prev_wdata = wdata_o;
  end

  // Advance to a sampling point 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic resp_cfg(input bit rg, input bit rd, input int fd, input bit drop);
    rand_gnt = rg; rand_dly = rd; fixed_dly = fd; drop_wr1 = drop;
    pending = 0; stuck = 0; rd_granted = 0;
    n_gnt = 0; outst_err = 0; stab_err = 0; stuck_cyc = 0;
    for (int i = 0; i < 16; i++) corrupt[i] = 32'h0;
  endtask

  // Drive start_i for one clock. This returns 2 units after the rising edge
  // that sampled it.
  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    while (done_o !== 1'b1 && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0;
    step(); step();
    n_cmp++; if ({req_o, we_o, addr_o} !== 6'h0) begin n_bad++;
      $display("FAIL reset_req_we_addr: got %h want 0", {req_o, we_o, addr_o}); end
    n_cmp++; if (wdata_o !== 32'h0) begin n_bad++;
      $display("FAIL reset_wdata: got %h want 0", wdata_o); end
    n_cmp++; if (be_o !== 4'hF) begin n_bad++;
      $display("FAIL reset_be: got %h want F", be_o); end
    n_cmp++; if ({busy_o, done_o, timeout_o} !== 3'b000) begin n_bad++;
      $display("FAIL reset_flags: got %b want 000", {busy_o, done_o, timeout_o}); end
    n_cmp++; if ({err_count_o, first_err_addr_o} !== 20'h0) begin n_bad++;
      $display("FAIL reset_err: got %h want 0", {err_count_o, first_err_addr_o}); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int k;
    resp_cfg(0, 0, 2, 0);
    pulse_start();
    n_cmp++; if ({busy_o, req_o, we_o, addr_o} !== 7'b1110000) begin n_bad++;
      $display("FAIL basic_first_req: got %b want 1110000", {busy_o, req_o, we_o, addr_o}); end
    n_cmp++; if (wdata_o !== 32'hA5C3_0F1E) begin n_bad++;
      $display("FAIL basic_first_wdata: got %h want A5C30F1E", wdata_o); end
    wait_done(200, k);
    n_cmp++; if (k !== 24) begin n_bad++;
      $display("FAIL basic_latency: got %0d want 24", k); end
    n_cmp++; if ({done_o, busy_o, timeout_o, err_count_o} !== {3'b100, 16'h0}) begin n_bad++;
      $display("FAIL basic_status: got %b/%h want 100/0", {done_o, busy_o, timeout_o}, err_count_o); end
    n_cmp++; if ({mem[0], mem[1]} !== {32'hA5C3_0F1E, 32'hA5C2_0F1F}) begin n_bad++;
      $display("FAIL basic_mem01: got %h %h want A5C30F1E A5C20F1F", mem[0], mem[1]); end
    n_cmp++; if ({mem[2], mem[3]} !== {32'hA5C1_0F1C, 32'hA5C0_0F1D}) begin n_bad++;
      $display("FAIL basic_mem23: got %h %h want A5C10F1C A5C00F1D", mem[2], mem[3]); end
    n_cmp++; if (n_gnt !== 8) begin n_bad++;
      $display("FAIL basic_grants: got %0d want 8", n_gnt); end
    n_cmp++; if ({req_o, addr_o} !== 5'h0) begin n_bad++;
      $display("FAIL basic_idle_bus: got %h want 0", {req_o, addr_o}); end
  endtask

  task automatic test_random_stall();
    int k;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    resp_cfg(1, 1, 0, 0);
    pulse_start();
    wait_done(3000, k);
    n_cmp++; if ({done_o, timeout_o, err_count_o} !== {2'b10, 16'h0}) begin n_bad++;
      $display("FAIL rand_status: got %b/%h want 10/0", {done_o, timeout_o}, err_count_o); end
    n_cmp++; if (stab_err !== 0) begin n_bad++;
      $display("FAIL rand_req_stable: got %0d violations want 0", stab_err); end
    n_cmp++; if (outst_err !== 0) begin n_bad++;
      $display("FAIL rand_outstanding: got %0d violations want 0", outst_err); end
    n_cmp++; if (n_gnt !== 8) begin n_bad++;
      $display("FAIL rand_grants: got %0d want 8", n_gnt); end
    n_cmp++; if (mem[3] !== 32'hA5C0_0F1D) begin n_bad++;
      $display("FAIL rand_mem3: got %h want A5C00F1D", mem[3]); end
  endtask

  task automatic test_corrupt();
    int k;
    resp_cfg(0, 0, 2, 0);
    corrupt[2] = 32'h0000_0001;
    corrupt[3] = 32'h0001_0000;
    pulse_start();
    wait_done(200, k);
    n_cmp++; if (err_count_o !== 16'd2) begin n_bad++;
      $display("FAIL corrupt_count: got %0d want 2", err_count_o); end
    n_cmp++; if (first_err_addr_o !== 4'd2) begin n_bad++;
      $display("FAIL corrupt_first: got %0d want 2", first_err_addr_o); end
    n_cmp++; if ({done_o, timeout_o} !== 2'b10) begin n_bad++;
      $display("FAIL corrupt_flags: got %b want 10", {done_o, timeout_o}); end
  endtask

  task automatic test_start_ignored();
    int k;
    resp_cfg(0, 0, 3, 0);
    pulse_start();
    n_cmp++; if ({err_count_o, first_err_addr_o, done_o, busy_o} !== {20'h0, 2'b01}) begin n_bad++;
      $display("FAIL restart_clear: got %h/%h/%b/%b want 0/0/0/1",
               err_count_o, first_err_addr_o, done_o, busy_o); end
    repeat (5) step();
    start_i = 1'b1;
    step(); step();
    start_i = 1'b0;
    wait_done(300, k);
    n_cmp++; if (n_gnt !== 8) begin n_bad++;
      $display("FAIL busy_start_grants: got %0d want 8", n_gnt); end
    n_cmp++; if ({done_o, err_count_o} !== {1'b1, 16'h0}) begin n_bad++;
      $display("FAIL busy_start_status: got %b/%h want 1/0", done_o, err_count_o); end
  endtask

  task automatic test_timeout();
    int k;
    int req_seen;
    resp_cfg(0, 0, 2, 1);
    pulse_start();
    k = 0;
    while (timeout_o !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    n_cmp++; if (cyc - stuck_cyc !== 64) begin n_bad++;
      $display("FAIL timeout_latency: got %0d want 64", cyc - stuck_cyc); end
    n_cmp++; if ({timeout_o, done_o, busy_o, err_count_o} !== {3'b110, 16'h0}) begin n_bad++;
      $display("FAIL timeout_status: got %b/%h want 110/0", {timeout_o, done_o, busy_o}, err_count_o); end
    n_cmp++; if (n_gnt !== 2) begin n_bad++;
      $display("FAIL timeout_grants: got %0d want 2", n_gnt); end
    req_seen = 0;
    repeat (10) begin
      step();
      if (req_o !== 1'b0) req_seen++;
    end
    n_cmp++; if (req_seen !== 0) begin n_bad++;
      $display("FAIL timeout_no_req: got %0d req cycles want 0", req_seen); end
  endtask

  task automatic test_reset_midrun();
    int k;
    resp_cfg(0, 0, 6, 0);
    pulse_start();
    k = 0;
    while (!rd_granted && k < 200) begin
      step();
      k++;
    end
    n_cmp++; if ({rd_granted, busy_o} !== 2'b11) begin n_bad++;
      $display("FAIL midrun_reached_read: got %b want 11", {rd_granted, busy_o}); end
    step();
    rst_ni = 1'b0;
    #1;
    n_cmp++; if ({req_o, we_o, addr_o, wdata_o, busy_o, done_o, timeout_o} !== 41'h0) begin n_bad++;
      $display("FAIL midrun_reset_outputs: got %h want 0",
               {req_o, we_o, addr_o, wdata_o, busy_o, done_o, timeout_o}); end
    n_cmp++; if ({be_o, err_count_o, first_err_addr_o} !== {4'hF, 20'h0}) begin n_bad++;
      $display("FAIL midrun_reset_status: got %h want F00000", {be_o, err_count_o, first_err_addr_o}); end
    step(); step();
    resp_cfg(0, 0, 2, 0);
    rst_ni = 1'b1;
    repeat (3) step();
    n_cmp++; if ({req_o, busy_o, done_o} !== 3'b000) begin n_bad++;
      $display("FAIL midrun_idle: got %b want 000", {req_o, busy_o, done_o}); end
    pulse_start();
    wait_done(200, k);
    n_cmp++; if ({done_o, timeout_o, err_count_o} !== {2'b10, 16'h0} || n_gnt !== 8) begin n_bad++;
      $display("FAIL midrun_clean_run: got %b/%h/%0d want 10/0/8",
               {done_o, timeout_o}, err_count_o, n_gnt); end
  endtask

  initial begin
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0;
    resp_cfg(0, 0, 2, 0);
    test_reset();
    test_basic();
    test_random_stall();
    test_corrupt();
    test_start_ignored();
    test_timeout();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
